// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access path.
package lc3_mem_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd3,
    HOLD = 3'd4
  } mem_state_t;

  localparam logic [15:0] LC3_IO_ADDR = 16'hFFFF;
  localparam int          SRAM_ADDR_W = 20;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter for one SRAM strobe phase; 'last' marks the final strobe cycle.
module mem_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  generate
    if (WAIT_CYCLES < 1) begin : g_bad_wait
      $error("mem_wait_counter: WAIT_CYCLES must be at least 1");
    end
  endgenerate

  logic [CW-1:0] r_count;

  // Count strobe cycles; never advances past WAIT_CYCLES-1.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign last = (r_count == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_ctrl.sv
// LC-3 SRAM bus-cycle controller with optional memory-mapped I/O.
// MEMCTRL_IO_MAP_EN enables IO_ADDR decoding (switches / hex display).
module sram_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = LC3_IO_ADDR
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Mem_OE,
  input  logic                   Mem_WE,
  input  logic [15:0]            MAR,
  input  logic [15:0]            MDR,
  output logic [15:0]            Data_to_CPU,
  output logic                   Mem_Ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  input  logic [15:0]            SRAM_DQ_in,
  output logic [15:0]            SRAM_DQ_out,
  output logic                   SRAM_DQ_oe,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  input  logic [15:0]            Switches,
  output logic [15:0]            HEX_Data
);

  mem_state_t  r_state;
  logic [15:0] r_mar;
  logic [15:0] r_mdr;
  logic [15:0] r_data;
  logic        r_ready;
  logic        r_dq_oe;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_bytes_n;
  logic        w_last;
  logic        w_cnt_clear;
  logic        w_cnt_enable;

  assign w_cnt_clear  = (r_state == IDLE);
  assign w_cnt_enable = ((r_state == RD) || (r_state == WR)) && !w_last;

  mem_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (w_cnt_clear),
    .enable(w_cnt_enable),
    .last  (w_last)
  );

`ifdef MEMCTRL_IO_MAP_EN
  logic [15:0] r_hex;
  logic        w_io_hit;

  assign w_io_hit = (MAR == IO_ADDR);
  assign HEX_Data = r_hex;

  // Hex-display register loads on an I/O-mapped write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hex <= 16'h0000;
    end else if ((r_state == IDLE) && Mem_WE && w_io_hit) begin
      r_hex <= MDR;
    end
  end
`else
  logic w_unused_io;

  assign w_unused_io = ^{Switches, IO_ADDR};
  assign HEX_Data    = 16'h0000;
`endif

  // Bus-cycle FSM; strobes and Ready are registered alongside the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_mar     <= 16'h0000;
      r_mdr     <= 16'h0000;
      r_data    <= 16'h0000;
      r_ready   <= 1'b0;
      r_dq_oe   <= 1'b0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_bytes_n <= 1'b1;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Mem_WE || Mem_OE) begin
            r_mar <= MAR;
            r_mdr <= MDR;
`ifdef MEMCTRL_IO_MAP_EN
            if (w_io_hit) begin
              r_state <= DONE;
              r_ready <= 1'b1;
              if (!Mem_WE) begin
                r_data <= Switches;
              end
            end else
`endif
            if (Mem_WE) begin
              // Write wins when both requests arrive together.
              r_state   <= WR;
              r_ce_n    <= 1'b0;
              r_we_n    <= 1'b0;
              r_bytes_n <= 1'b0;
              r_dq_oe   <= 1'b1;
            end else begin
              r_state   <= RD;
              r_ce_n    <= 1'b0;
              r_oe_n    <= 1'b0;
              r_bytes_n <= 1'b0;
            end
          end
        end
        RD: begin
          if (w_last) begin
            r_data    <= SRAM_DQ_in;
            r_state   <= DONE;
            r_ready   <= 1'b1;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_bytes_n <= 1'b1;
          end
        end
        WR: begin
          if (w_last) begin
            // Bus drive is kept through DONE for data hold.
            r_state   <= DONE;
            r_ready   <= 1'b1;
            r_ce_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_bytes_n <= 1'b1;
          end
        end
        DONE: begin
          r_state <= HOLD;
          r_dq_oe <= 1'b0;
        end
        HOLD: begin
          if (!Mem_OE && !Mem_WE) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_dq_oe   <= 1'b0;
          r_ce_n    <= 1'b1;
          r_oe_n    <= 1'b1;
          r_we_n    <= 1'b1;
          r_bytes_n <= 1'b1;
        end
      endcase
    end
  end

  assign Data_to_CPU = r_data;
  assign Mem_Ready   = r_ready;
  assign SRAM_ADDR   = {4'b0000, r_mar};
  assign SRAM_DQ_out = r_mdr;
  assign SRAM_DQ_oe  = r_dq_oe;
  assign SRAM_CE_N   = r_ce_n;
  assign SRAM_OE_N   = r_oe_n;
  assign SRAM_WE_N   = r_we_n;
  assign SRAM_UB_N   = r_bytes_n;
  assign SRAM_LB_N   = r_bytes_n;

endmodule
